fifo_read_ctrl: RTL and testbench
=================================

// Module: fifo_read_ctrl
// PURPOSE
//  Read-side drain engine for the FIFO. Pulls a programmed burst of words through
//  rd_en/empty/data_out and re-presents them downstream on a valid/ready stream.
//  Absorbs the FIFO's 1-cycle read latency with a 2-entry skid buffer, giving full
//  throughput and no loss under backpressure. Sits in the read clock domain.
// PARAMETERS
//  DATA_WIDTH  32  width of FIFO words and m_data
//  CNT_WIDTH   16  width of len and word_count
// PORTS
//  clk          in   1           read-domain clock
//  rst          in   1           synchronous reset, active-high
//  start        in   1           1-cycle pulse: begin a burst of len words
//  len          in   CNT_WIDTH   burst length, sampled with start
//  fifo_empty   in   1           FIFO empty flag
//  fifo_data    in   DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
//  fifo_rd_en   out  1           FIFO read strobe
//  m_data       out  DATA_WIDTH  downstream data (skid head)
//  m_valid      out  1           downstream valid
//  m_ready      in   1           downstream ready
//  word_count   out  CNT_WIDTH   words accepted downstream in current/last burst
//  busy         out  1           state != IDLE
//  done         out  1           1-cycle pulse when burst fully delivered
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; fifo_rd_en, m_valid, busy, done = 0;
//   m_data, word_count = 0; skid cleared; in-flight flag cleared. A word returning
//   from a read issued before reset is discarded, never presented.
//  FSM: IDLE -> RUN on start && len!=0 (issued_cnt<=0, word_count<=0).
//   IDLE + start && len==0 -> done=1 next cycle, no reads, stay IDLE.
//   RUN -> DRAIN when issued_cnt reaches len. DRAIN -> IDLE when skid empty and
//   no read in flight; done=1 that same cycle. start while busy is ignored.
//  Read issue (comb): fifo_rd_en = (state==RUN) && !fifo_empty && issued_cnt<len
//   && (held + inflight - pop) < 2, where pop = m_valid && m_ready.
//  Latency: inflight <= fifo_rd_en; when inflight=1, fifo_data is written into the
//   skid at that cycle's posedge. Word appears on m_valid 2 cycles after its rd_en.
//  Skid: 2 entries, FIFO order. m_valid = held!=0; m_data = head entry.
//   Simultaneous push and pop in one cycle: legal, held unchanged, order kept.
//   Overflow impossible by issue rule; verification asserts held<=2.
//  Handshake: m_data/m_valid stable while m_valid && !m_ready.
//  word_count increments on each pop; holds after done until next accepted start.
//  Counters saturate at len; no wrap within a burst (len <= 2^CNT_WIDTH-1).
//  fifo_empty rising mid-burst: issue stalls, in-flight word still captured; resumes
//   on fifo_empty=0 with no duplicated or skipped word.
// TESTING
//  1 rst=1 for 3 cycles with all inputs random -> every output 0; no rd_en after.
//  2 FIFO holds A0..A7, m_ready=1, start len=4 -> rd_en high 4 consecutive cycles;
//    m_data A0..A3 on 4 consecutive cycles starting 2 cycles after 1st rd_en;
//    done 1 pulse; word_count=4; A4 remains in FIFO.
//  3 len=8, m_ready=0 for 10 cycles then 1 -> exactly 2 rd_en before stall; all 8
//    words delivered in order, m_data stable while stalled.
//  4 len=6, fifo_empty=1 for 5 cycles after 2nd read -> rd_en low during empty;
//    6 words in order; word_count=6; done once.
//  5 rst pulse after 2 handshakes of len=5 -> outputs 0 next cycle; in-flight word
//    dropped; then start len=2 -> next 2 FIFO words delivered, done.
//  6 start len=0 -> done next cycle, no rd_en; start during busy -> ignored, len
//    unchanged, single done for original burst.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// Read-side drain engine: issues FIFO reads for a programmed burst and replays the
// words on a valid/ready stream. A 2-entry skid buffer absorbs the 1-cycle read latency.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                         state;
  logic [CNT_WIDTH-1:0]           len_q;
  logic [CNT_WIDTH-1:0]           issued_cnt;
  logic                           inflight;
  logic [1:0]                     held;
  logic [1:0][DATA_WIDTH-1:0]     skid;

  logic                           pop;
  logic                           push;
  logic [2:0]                     occ;
  logic [1:0]                     held_n;

  assign pop     = m_valid && m_ready;
  assign push    = inflight;
  assign m_valid = (held != 2'd0);
  assign m_data  = skid[0];

  // Occupancy the skid will have after this edge; pop implies held>=1 so no underflow.
  assign occ    = {1'b0, held} + {2'b00, inflight} - {2'b00, pop};
  assign held_n = occ[1:0];

  // A new read is only allowed if its word is guaranteed a slot when it lands.
  assign fifo_rd_en = (state == RUN) && !fifo_empty && (issued_cnt < len_q) && (occ < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      issued_cnt <= '0;
      inflight   <= 1'b0;
      held       <= 2'd0;
      skid       <= '0;
      word_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= fifo_rd_en;
      held     <= held_n;

      // skid[0] is always the head; a push lands behind whatever survives the pop.
      case ({push, pop})
        2'b10: skid[held[0]] <= fifo_data;
        2'b01: skid[0] <= skid[1];
        2'b11: begin
          if (held == 2'd2) begin
            skid[0] <= skid[1];
            skid[1] <= fifo_data;
          end else begin
            skid[0] <= fifo_data;
          end
        end
        default: ;
      endcase

      if (pop && (word_count != len_q))
        word_count <= word_count + CNT_ONE;

      if (fifo_rd_en)
        issued_cnt <= issued_cnt + CNT_ONE;

      case (state)
        IDLE: begin
          if (start) begin
            len_q      <= len;
            issued_cnt <= '0;
            word_count <= '0;
            if (len != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (fifo_rd_en && (issued_cnt == len_q - CNT_ONE))
            state <= DRAIN;
        end
        DRAIN: begin
          // No reads are issued here, so nothing new can enter flight.
          if ((held_n == 2'd0) && !fifo_rd_en) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a behavioural 1-cycle-latency FIFO in front.
module tb_fifo_read_ctrl;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, m_ready, hold_empty, flush;
  logic [CW-1:0] len;
  logic          fifo_empty, fifo_rd_en, m_valid, busy, done;
  logic [DW-1:0] fifo_data = '0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] word_count;

  logic [DW-1:0] mem [0:63];
  int rd_ptr = 0;
  int wr_ptr = 0;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int rd_log[$];
  int hs_cyc[$];
  logic [DW-1:0] out_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int held_viol = 0;
  int stall_viol = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always #5 clk = ~clk;

  fifo_read_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .word_count(word_count), .busy(busy), .done(done)
  );

  // FIFO model: data appears the cycle after the read strobe.
  assign fifo_empty = hold_empty || (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  // Observe the current cycle mid-way, then advance to just after the next edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (fifo_rd_en) rd_log.push_back(cyc);
    if (m_valid && m_ready) begin out_q.push_back(m_data); hs_cyc.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (dut.held > 2'd2) held_viol++;
    if (prev_stall && (!m_valid || m_data !== prev_data)) stall_viol++;
    prev_stall = m_valid && !m_ready && !rst;
    prev_data  = m_data;
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    rd_log.delete(); hs_cyc.delete(); out_q.delete();
    done_cnt = 0; done_cyc = 0;
  endtask

  task automatic flush_fifo();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      start = 1'($urandom_range(0, 1)); len = CW'($urandom);
      m_ready = 1'($urandom_range(0, 1)); hold_empty = 1'($urandom_range(0, 1));
      tick();
    end
    cmp_cnt++; if (fifo_rd_en !== 1'b0) begin err_cnt++; $display("FAIL reset_rd_en: got %0h want 0", fifo_rd_en); end
    cmp_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_m_valid: got %0h want 0", m_valid); end
    cmp_cnt++; if (m_data !== '0) begin err_cnt++; $display("FAIL reset_m_data: got %0h want 0", m_data); end
    cmp_cnt++; if (word_count !== '0) begin err_cnt++; $display("FAIL reset_word_count: got %0h want 0", word_count); end
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %0h want 0", busy); end
    cmp_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %0h want 0", done); end
    rst = 1'b0; start = 1'b0; len = '0; m_ready = 1'b0; hold_empty = 1'b0;
    clear_logs();
    repeat (4) tick();
    cmp_cnt++; if (rd_log.size() != 0) begin err_cnt++; $display("FAIL post_reset_rd: got %0d reads want 0", rd_log.size()); end
    cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL post_reset_busy: got %0h want 0", busy); end
  endtask

  task automatic test_basic();
    flush_fifo();
    for (int i = 0; i < 8; i++) push(32'hA000_0000 + i);
    m_ready = 1'b1; clear_logs();
    start = 1'b1; len = 16'd4; tick(); start = 1'b0;
    for (int i = 0; i < 40 && done_cnt == 0; i++) tick();
    repeat (3) tick();
    cmp_cnt++; if (rd_log.size() != 4 || rd_log[3] - rd_log[0] != 3) begin err_cnt++; $display("FAIL basic_rd_burst: got %0d reads want 4 consecutive", rd_log.size()); end
    cmp_cnt++; if (out_q.size() != 4) begin err_cnt++; $display("FAIL basic_count: got %0d words want 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      cmp_cnt++; if (out_q[i] !== 32'hA000_0000 + i) begin err_cnt++; $display("FAIL basic_data%0d: got %0h want %0h", i, out_q[i], 32'hA000_0000 + i); end
    end
    cmp_cnt++; if (hs_cyc.size() != 4 || rd_log.size() == 0 || hs_cyc[0] - rd_log[0] != 2 || hs_cyc[3] - hs_cyc[0] != 3) begin err_cnt++; $display("FAIL basic_latency: got %0d handshakes, latency/spacing wrong", hs_cyc.size()); end
    cmp_cnt++; if (done_cnt != 1) begin err_cnt++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    cmp_cnt++; if (hs_cyc.size() != 4 || done_cyc != hs_cyc[3] + 1) begin err_cnt++; $display("FAIL basic_done_time: got cycle %0d want one after last handshake", done_cyc); end
    cmp_cnt++; if (word_count !== 16'd4) begin err_cnt++; $display("FAIL basic_word_count: got %0d want 4", word_count); end
    cmp_cnt++; if (wr_ptr - rd_ptr != 4 || mem[rd_ptr % 64] !== 32'hA000_0004) begin err_cnt++; $display("FAIL basic_leftover: got %0d left head %0h want 4 head a0000004", wr_ptr - rd_ptr, mem[rd_ptr % 64]); end
  endtask

  task automatic test_backpressure();
    flush_fifo();
    for (int i = 0; i < 8; i++) push(32'hB000_0000 + i);
    m_ready = 1'b0; clear_logs();
    start = 1'b1; len = 16'd8; tick(); start = 1'b0;
    repeat (9) tick();
    cmp_cnt++; if (rd_log.size() != 2) begin err_cnt++; $display("FAIL bp_reads_stalled: got %0d want 2", rd_log.size()); end
    cmp_cnt++; if (m_valid !== 1'b1 || m_data !== 32'hB000_0000) begin err_cnt++; $display("FAIL bp_head: got v=%0h d=%0h want v=1 d=b0000000", m_valid, m_data); end
    m_ready = 1'b1;
    for (int i = 0; i < 60 && done_cnt == 0; i++) tick();
    repeat (3) tick();
    cmp_cnt++; if (out_q.size() != 8) begin err_cnt++; $display("FAIL bp_count: got %0d words want 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      cmp_cnt++; if (out_q[i] !== 32'hB000_0000 + i) begin err_cnt++; $display("FAIL bp_data%0d: got %0h want %0h", i, out_q[i], 32'hB000_0000 + i); end
    end
    cmp_cnt++; if (word_count !== 16'd8) begin err_cnt++; $display("FAIL bp_word_count: got %0d want 8", word_count); end
    cmp_cnt++; if (done_cnt != 1) begin err_cnt++; $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_empty_stall();
    flush_fifo();
    for (int i = 0; i < 6; i++) push(32'hC000_0000 + i);
    m_ready = 1'b1; clear_logs();
    start = 1'b1; len = 16'd6; tick(); start = 1'b0;
    tick(); tick();
    hold_empty = 1'b1;
    cmp_cnt++; if (rd_log.size() != 2) begin err_cnt++; $display("FAIL empty_pre_reads: got %0d want 2", rd_log.size()); end
    repeat (5) tick();
    cmp_cnt++; if (rd_log.size() != 2) begin err_cnt++; $display("FAIL empty_no_read: got %0d reads want 2", rd_log.size()); end
    hold_empty = 1'b0;
    for (int i = 0; i < 60 && done_cnt == 0; i++) tick();
    repeat (3) tick();
    cmp_cnt++; if (out_q.size() != 6) begin err_cnt++; $display("FAIL empty_count: got %0d words want 6", out_q.size()); end
    for (int i = 0; i < 6 && i < out_q.size(); i++) begin
      cmp_cnt++; if (out_q[i] !== 32'hC000_0000 + i) begin err_cnt++; $display("FAIL empty_data%0d: got %0h want %0h", i, out_q[i], 32'hC000_0000 + i); end
    end
    cmp_cnt++; if (rd_log.size() != 6) begin err_cnt++; $display("FAIL empty_total_reads: got %0d want 6", rd_log.size()); end
    cmp_cnt++; if (word_count !== 16'd6) begin err_cnt++; $display("FAIL empty_word_count: got %0d want 6", word_count); end
    cmp_cnt++; if (done_cnt != 1) begin err_cnt++; $display("FAIL empty_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_midburst();
    logic [DW-1:0] exp0, exp1;
    flush_fifo();
    for (int i = 0; i < 7; i++) push(32'hD000_0000 + i);
    m_ready = 1'b1; clear_logs();
    start = 1'b1; len = 16'd5; tick(); start = 1'b0;
    for (int i = 0; i < 20 && hs_cyc.size() < 2; i++) tick();
    cmp_cnt++; if (out_q.size() < 2 || out_q[0] !== 32'hD000_0000 || out_q[1] !== 32'hD000_0001) begin err_cnt++; $display("FAIL mid_pre_words: got %0d words want D0,D1 first", out_q.size()); end
    rst = 1'b1; tick(); rst = 1'b0;
    cmp_cnt++; if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || fifo_rd_en !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_ctrl: got v=%0h b=%0h d=%0h rd=%0h want 0", m_valid, busy, done, fifo_rd_en); end
    cmp_cnt++; if (m_data !== '0 || word_count !== '0) begin err_cnt++; $display("FAIL mid_rst_data: got d=%0h wc=%0h want 0", m_data, word_count); end
    repeat (3) tick();
    cmp_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_inflight_dropped: got m_valid %0h want 0", m_valid); end
    exp0 = mem[rd_ptr % 64]; exp1 = mem[(rd_ptr + 1) % 64];
    clear_logs();
    start = 1'b1; len = 16'd2; tick(); start = 1'b0;
    for (int i = 0; i < 40 && done_cnt == 0; i++) tick();
    repeat (3) tick();
    cmp_cnt++; if (out_q.size() != 2 || out_q[0] !== exp0 || out_q[1] !== exp1) begin err_cnt++; $display("FAIL mid_restart_data: got %0d words want %0h,%0h", out_q.size(), exp0, exp1); end
    cmp_cnt++; if (done_cnt != 1 || word_count !== 16'd2) begin err_cnt++; $display("FAIL mid_restart_done: got done %0d wc %0d want 1,2", done_cnt, word_count); end
  endtask

  task automatic test_len0_and_busy_start();
    flush_fifo();
    m_ready = 1'b1; clear_logs();
    start = 1'b1; len = 16'd0; tick(); start = 1'b0;
    cmp_cnt++; if (done !== 1'b1 || busy !== 1'b0) begin err_cnt++; $display("FAIL len0_done: got done=%0h busy=%0h want 1,0", done, busy); end
    repeat (3) tick();
    cmp_cnt++; if (rd_log.size() != 0 || done_cnt != 1) begin err_cnt++; $display("FAIL len0_quiet: got %0d reads %0d dones want 0,1", rd_log.size(), done_cnt); end
    for (int i = 0; i < 6; i++) push(32'hF000_0000 + i);
    clear_logs();
    start = 1'b1; len = 16'd3; tick(); start = 1'b0;
    cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL busy_set: got %0h want 1", busy); end
    start = 1'b1; len = 16'd5; tick(); start = 1'b0;
    for (int i = 0; i < 40 && done_cnt == 0; i++) tick();
    repeat (4) tick();
    cmp_cnt++; if (rd_log.size() != 3) begin err_cnt++; $display("FAIL busy_reads: got %0d want 3", rd_log.size()); end
    cmp_cnt++; if (out_q.size() != 3 || out_q[0] !== 32'hF000_0000 || out_q[2] !== 32'hF000_0002) begin err_cnt++; $display("FAIL busy_data: got %0d words want F0..F2", out_q.size()); end
    cmp_cnt++; if (done_cnt != 1 || word_count !== 16'd3) begin err_cnt++; $display("FAIL busy_done: got done %0d wc %0d want 1,3", done_cnt, word_count); end
    cmp_cnt++; if (wr_ptr - rd_ptr != 3) begin err_cnt++; $display("FAIL busy_leftover: got %0d want 3", wr_ptr - rd_ptr); end
  endtask

  task automatic test_invariants();
    cmp_cnt++; if (held_viol != 0) begin err_cnt++; $display("FAIL skid_overflow: got %0d cycles with held>2 want 0", held_viol); end
    cmp_cnt++; if (stall_viol != 0) begin err_cnt++; $display("FAIL stall_stability: got %0d unstable cycles want 0", stall_viol); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; m_ready = 1'b0; hold_empty = 1'b0; flush = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_reset_midburst();
    test_len0_and_busy_start();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
